// File: rtl/io_uart_tx_pkg.sv
// Shared constants for the IO-mapped UART transmitter: register addresses,
// status bit positions and the shifter state encoding.
package io_uart_tx_pkg;

  localparam logic [15:0] TX_DATA   = 16'h1000;
  localparam logic [15:0] TX_DIV    = 16'h100C;
  localparam logic [15:0] TX_STATUS = 16'h2000;

  localparam int ST_NOT_FULL = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int ST_TX_IDLE  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  function automatic logic [15:0] status_word(input logic not_full,
                                              input logic overrun,
                                              input logic tx_idle);
    logic [15:0] s;
    s              = '0;
    s[ST_NOT_FULL] = not_full;
    s[ST_OVERRUN]  = overrun;
    s[ST_TX_IDLE]  = tx_idle;
    return s;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU IO bus seen by the UART transmitter: strobes, address, write data and
// registered read data.
interface io_uart_tx_if;
  logic        io_wr;
  logic        io_rd;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] din;

  modport master (output io_wr, output io_rd, output mem_addr, output dout, input din);
  modport slave  (input io_wr, input io_rd, input mem_addr, input dout, output din);
endinterface

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes when full and pops when
// empty are ignored, pointers wrap naturally on a power-of-two depth.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// IO-mapped 8N1 UART transmitter: byte FIFO, programmable bit divisor,
// sticky overrun status and a registered serial output.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLKFREQ = 50000000,
  parameter int DEPTH   = 16
) (
  input  logic         clk,
  input  logic         reset,
  io_uart_tx_if.slave  bus,
  output logic         tx,
  output logic         irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLKFREQ / 115200 - 1);

  logic        wr_data, wr_div, rd_status;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_dout;
  logic        tx_idle;
  logic [15:0] rd_data;

  logic [15:0] div_q;
  logic        overrun_q;
  logic [15:0] din_q;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign wr_data   = bus.io_wr && (bus.mem_addr == TX_DATA);
  assign wr_div    = bus.io_wr && (bus.mem_addr == TX_DIV);
  assign rd_status = bus.io_rd && (bus.mem_addr == TX_STATUS);

  io_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (wr_data),
    .pop  (fifo_pop),
    .din  (bus.dout[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign tx_idle = fifo_empty && (state_q == S_IDLE);
  assign irq     = tx_idle;
  assign tx      = tx_q;
  assign bus.din = din_q;

  always_comb begin
    rd_data = 16'h0000;
    case (bus.mem_addr)
      TX_DIV:    rd_data = div_q;
      TX_STATUS: rd_data = status_word(!fifo_full, overrun_q, tx_idle);
      default:   rd_data = 16'h0000;
    endcase
  end

  // Overrun from a dropped byte wins over a clearing status read in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= DIV_RESET;
      overrun_q <= 1'b0;
      din_q     <= 16'h0000;
    end else begin
      din_q <= rd_data;
      if (wr_div) div_q <= bus.dout;
      if (wr_data && fifo_full) overrun_q <= 1'b1;
      else if (rd_status)       overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_lat_q <= DIV_RESET;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
    end
  end

  assign bit_end = (cnt_q == div_lat_q);

  // tx_d is the level of the bit that begins on the next edge, so tx stays registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          div_lat_d = div_q;
          cnt_d     = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            div_lat_d = div_q;
            state_d   = S_START;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
